// File: rtl/riscv_pkg.sv
// Shared definitions for the RV32I pipeline memory stage.
//   - WriteSrc encodings selecting the writeback source
//   - funct3 load/store size and sign encodings
//   - memory-access FSM states and access-size decode helper
package riscv_pkg;

  localparam logic [1:0] WSRC_ALU = 2'b00;
  localparam logic [1:0] WSRC_MEM = 2'b01;
  localparam logic [1:0] WSRC_PC4 = 2'b10;
  localparam logic [1:0] WSRC_IMM = 2'b11;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'b00,
    MEM_BUSY = 2'b01,
    MEM_DONE = 2'b10
  } mem_state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } acc_size_e;

  // Unsigned encodings only exist for loads; any funct3 not listed is a word.
  function automatic acc_size_e access_size(input logic is_store, input logic [2:0] funct3);
    if (funct3 == F3_B || (!is_store && funct3 == F3_BU)) return SZ_BYTE;
    if (funct3 == F3_H || (!is_store && funct3 == F3_HU)) return SZ_HALF;
    return SZ_WORD;
  endfunction

endpackage

// File: rtl/load_store_align.sv
// Combinational data-memory lane handling.
//   i_store       : access is a store (selects store size table)
//   i_funct3      : size / sign field
//   i_addr_lo     : byte offset within the word
//   i_store_data  : register data to store
//   i_load_word   : raw word returned by memory
//   o_be          : byte enables
//   o_wdata       : store data replicated across lanes
//   o_mis         : access is misaligned for its size
//   o_load_data   : selected lane, sign- or zero-extended
module load_store_align
  import riscv_pkg::*;
(
  input  logic        i_store,
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_store_data,
  input  logic [31:0] i_load_word,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic        o_mis,
  output logic [31:0] o_load_data
);

  acc_size_e   w_size;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_size      = access_size(i_store, i_funct3);
    w_byte      = i_load_word[{i_addr_lo, 3'b000} +: 8];
    w_half      = i_load_word[{i_addr_lo[1], 4'b0000} +: 16];
    o_be        = 4'b1111;
    o_wdata     = i_store_data;
    o_mis       = 1'b0;
    o_load_data = i_load_word;
    case (w_size)
      SZ_BYTE: begin
        o_be        = 4'b0001 << i_addr_lo;
        o_wdata     = {4{i_store_data[7:0]}};
        o_load_data = i_funct3[2] ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
      end
      SZ_HALF: begin
        o_be        = 4'b0011 << i_addr_lo;
        o_wdata     = {2{i_store_data[15:0]}};
        o_mis       = i_addr_lo[0];
        o_load_data = i_funct3[2] ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
      end
      default: begin
        o_mis = |i_addr_lo;
      end
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// RV32I memory stage: resolves control-flow redirects, runs loads/stores
// over a req/ack data-memory port and drives the MEM/WB register.
//   clk_i, rst_i              : clock, synchronous active-high reset
//   valid_i .. rd_i           : EX/MEM register contents
//   ALUResultM_o              : ALU result forwarded to EX
//   stall_o                   : freeze PC, IF/ID, ID/EX, EX/MEM
//   PCsrc_o, PCtarget_o       : redirect request and target
//   dmem_*                    : data-memory request port
//   RegWrite_o .. rd_o        : MEM/WB register
//   fault_o                   : one-cycle pulse on misaligned or timed-out access
module mem_stage
  import riscv_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  input  logic        EQ_i,
  input  logic [31:0] ALUout_i,
  input  logic        RegWrite_i,
  input  logic [1:0]  WriteSrc_i,
  input  logic        Branch_i,
  input  logic        Jump_i,
  input  logic        Ret_i,
  input  logic        MemWrite_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] ImmOp_i,
  input  logic [31:0] pcPlus4_i,
  input  logic [31:0] pcPlusImm_i,
  input  logic [31:0] regOp2_i,
  input  logic [4:0]  rd_i,
  output logic [31:0] ALUResultM_o,
  output logic        stall_o,
  output logic        PCsrc_o,
  output logic [31:0] PCtarget_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  output logic [3:0]  dmem_be_o,
  input  logic        dmem_ack_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        RegWrite_o,
  output logic [1:0]  WriteSrc_o,
  output logic [31:0] ALUout_o,
  output logic [31:0] ReadData_o,
  output logic [31:0] pcPlus4_o,
  output logic [31:0] ImmOp_o,
  output logic [4:0]  rd_o,
  output logic        fault_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  mem_state_e       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_abort;
  logic [31:0]      r_rdata;

  logic        w_acc;
  logic        w_mis;
  logic        w_issue;
  logic        w_cf_en;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_load_data;

  // EX/MEM is frozen while stalled, so the live inputs still describe the
  // outstanding access when rdata returns.
  load_store_align u_align (
    .i_store      (MemWrite_i),
    .i_funct3     (funct3_i),
    .i_addr_lo    (ALUout_i[1:0]),
    .i_store_data (regOp2_i),
    .i_load_word  (dmem_rdata_i),
    .o_be         (w_be),
    .o_wdata      (w_wdata),
    .o_mis        (w_mis),
    .o_load_data  (w_load_data)
  );

  always_comb begin
    w_acc        = valid_i & (MemWrite_i | (WriteSrc_i == WSRC_MEM));
    w_issue      = (r_state == MEM_IDLE) & w_acc & ~w_mis;
    stall_o      = w_issue | (r_state == MEM_BUSY);
    w_cf_en      = valid_i & ~stall_o;
    PCsrc_o      = w_cf_en & ((Branch_i & EQ_i) | Jump_i);
    PCtarget_o   = Ret_i ? ALUout_i : pcPlusImm_i;
    ALUResultM_o = ALUout_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= MEM_IDLE;
      r_cnt        <= '0;
      r_abort      <= 1'b0;
      r_rdata      <= '0;
      dmem_req_o   <= 1'b0;
      dmem_we_o    <= 1'b0;
      dmem_addr_o  <= '0;
      dmem_wdata_o <= '0;
      dmem_be_o    <= '0;
      fault_o      <= 1'b0;
      RegWrite_o   <= 1'b0;
      WriteSrc_o   <= '0;
      ALUout_o     <= '0;
      ReadData_o   <= '0;
      pcPlus4_o    <= '0;
      ImmOp_o      <= '0;
      rd_o         <= '0;
    end else begin
      fault_o <= 1'b0;

      case (r_state)
        MEM_IDLE: begin
          r_cnt   <= '0;
          r_abort <= 1'b0;
          if (w_issue) begin
            dmem_req_o   <= 1'b1;
            dmem_we_o    <= MemWrite_i;
            dmem_addr_o  <= {ALUout_i[31:2], 2'b00};
            dmem_wdata_o <= w_wdata;
            dmem_be_o    <= w_be;
            r_state      <= MEM_BUSY;
          end else if (w_acc) begin
            fault_o <= 1'b1;
          end
        end
        MEM_BUSY: begin
          if (dmem_ack_i) begin
            dmem_req_o <= 1'b0;
            r_rdata    <= w_load_data;
            r_state    <= MEM_DONE;
          end else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            dmem_req_o <= 1'b0;
            r_abort    <= 1'b1;
            fault_o    <= 1'b1;
            r_state    <= MEM_DONE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        MEM_DONE: r_state <= MEM_IDLE;
        default:  r_state <= MEM_IDLE;
      endcase

      // In IDLE an unstalled access can only be a misaligned one: it retires as a bubble.
      if (r_state == MEM_DONE) begin
        RegWrite_o <= RegWrite_i & ~r_abort;
        WriteSrc_o <= WriteSrc_i;
        ALUout_o   <= ALUout_i;
        ReadData_o <= r_rdata;
        pcPlus4_o  <= pcPlus4_i;
        ImmOp_o    <= ImmOp_i;
        rd_o       <= rd_i;
      end else if (stall_o | ~valid_i | w_acc) begin
        RegWrite_o <= 1'b0;
        WriteSrc_o <= '0;
        ALUout_o   <= '0;
        ReadData_o <= '0;
        pcPlus4_o  <= '0;
        ImmOp_o    <= '0;
        rd_o       <= '0;
      end else begin
        RegWrite_o <= RegWrite_i;
        WriteSrc_o <= WriteSrc_i;
        ALUout_o   <= ALUout_i;
        ReadData_o <= '0;
        pcPlus4_o  <= pcPlus4_i;
        ImmOp_o    <= ImmOp_i;
        rd_o       <= rd_i;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed cases followed by randomized
// instructions, checked against a byte-addressed reference model.
module tb_mem_stage;

  localparam int unsigned TO = 4;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        valid_i, EQ_i, RegWrite_i, Branch_i, Jump_i, Ret_i, MemWrite_i;
  logic [31:0] ALUout_i, ImmOp_i, pcPlus4_i, pcPlusImm_i, regOp2_i;
  logic [1:0]  WriteSrc_i;
  logic [2:0]  funct3_i;
  logic [4:0]  rd_i;
  logic [31:0] ALUResultM_o, PCtarget_o, dmem_addr_o, dmem_wdata_o;
  logic        stall_o, PCsrc_o, dmem_req_o, dmem_we_o;
  logic [3:0]  dmem_be_o;
  logic        dmem_ack_i;
  logic [31:0] dmem_rdata_i;
  logic        RegWrite_o, fault_o;
  logic [1:0]  WriteSrc_o;
  logic [31:0] ALUout_o, ReadData_o, pcPlus4_o, ImmOp_o;
  logic [4:0]  rd_o;

  always #5 clk_i = ~clk_i;

  mem_stage #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .EQ_i(EQ_i), .ALUout_i(ALUout_i),
    .RegWrite_i(RegWrite_i), .WriteSrc_i(WriteSrc_i), .Branch_i(Branch_i), .Jump_i(Jump_i),
    .Ret_i(Ret_i), .MemWrite_i(MemWrite_i), .funct3_i(funct3_i), .ImmOp_i(ImmOp_i),
    .pcPlus4_i(pcPlus4_i), .pcPlusImm_i(pcPlusImm_i), .regOp2_i(regOp2_i), .rd_i(rd_i),
    .ALUResultM_o(ALUResultM_o), .stall_o(stall_o), .PCsrc_o(PCsrc_o), .PCtarget_o(PCtarget_o),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_wdata_o(dmem_wdata_o), .dmem_be_o(dmem_be_o), .dmem_ack_i(dmem_ack_i),
    .dmem_rdata_i(dmem_rdata_i), .RegWrite_o(RegWrite_o), .WriteSrc_o(WriteSrc_o),
    .ALUout_o(ALUout_o), .ReadData_o(ReadData_o), .pcPlus4_o(pcPlus4_o), .ImmOp_o(ImmOp_o),
    .rd_o(rd_o), .fault_o(fault_o)
  );

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // Memory seen by the DUT (written through its byte enables) and the
  // reference model's own byte image of the same region at 0x100.
  logic [31:0] dmem  [16];
  logic [7:0]  mbyte [64];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic int unsigned acc_bytes(input logic st, input logic [2:0] f3);
    if (f3 == 3'b000 || (!st && f3 == 3'b100)) return 1;
    if (f3 == 3'b001 || (!st && f3 == 3'b101)) return 2;
    return 4;
  endfunction

  task automatic set_word(input int unsigned idx, input logic [31:0] w);
    dmem[idx] = w;
    for (int unsigned j = 0; j < 4; j++) mbyte[4*idx + j] = w[8*j +: 8];
  endtask

  // Called just after a rising edge; returns just after the edge at which
  // the instruction leaves the stage.
  task automatic run_instr(input logic v, input logic mw, input logic [1:0] ws, input logic rw,
                           input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] data,
                           input logic br, input logic jp, input logic rt, input logic eq,
                           input logic [31:0] pci, input logic [4:0] rd, input int unsigned lat);
    logic [31:0] imm, pc4, exp_tgt, exp_be, exp_wdata, exp_load;
    logic        acc, mis, tmo, exp_pcsrc, exp_rw, done;
    int unsigned sz, lo, bi, busy_exp, stall_exp, k, busy_seen;
    imm = $urandom; pc4 = $urandom;
    valid_i = v; MemWrite_i = mw; WriteSrc_i = ws; RegWrite_i = rw; funct3_i = f3;
    ALUout_i = addr; regOp2_i = data; Branch_i = br; Jump_i = jp; Ret_i = rt; EQ_i = eq;
    pcPlusImm_i = pci; rd_i = rd; ImmOp_i = imm; pcPlus4_i = pc4;

    sz        = acc_bytes(mw, f3);
    lo        = addr % 4;
    bi        = addr % 64;
    acc       = v && (mw || ws == 2'b01);
    mis       = acc && (addr % sz != 0);
    tmo       = acc && !mis && (lat > TO);
    busy_exp  = (acc && !mis) ? ((lat < TO) ? lat : TO) : 0;
    stall_exp = (busy_exp != 0) ? busy_exp + 1 : 0;
    exp_pcsrc = v && ((br && eq) || jp);
    exp_tgt   = rt ? addr : pci;
    exp_be    = '0;
    exp_wdata = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (i >= lo && i < lo + sz) exp_be[i] = 1'b1;
      exp_wdata[8*i +: 8] = data[8*(i % sz) +: 8];
    end
    exp_load = '0;
    if (!mis) begin
      for (int unsigned i = 0; i < sz; i++) exp_load = exp_load | (32'(mbyte[(bi + i) % 64]) << (8*i));
      if (sz < 4 && (f3 == 3'b000 || f3 == 3'b001) && exp_load[8*sz-1])
        exp_load = exp_load | (32'hFFFF_FFFF << (8*sz));
    end

    k = 0; busy_seen = 0; done = 1'b0;
    while (!done) begin
      @(negedge clk_i);
      check_eq("stall", stall_o, (k < stall_exp));
      check_eq("pcsrc", PCsrc_o, (k >= stall_exp) && exp_pcsrc);
      if (exp_pcsrc && k >= stall_exp) check_eq("pctarget", PCtarget_o, exp_tgt);
      check_eq("alu_fwd", ALUResultM_o, addr);
      if (k > 0) check_eq("fault_window", fault_o, tmo && (k == stall_exp));
      dmem_ack_i   = 1'b0;
      dmem_rdata_i = $urandom;
      if (dmem_req_o) begin
        busy_seen++;
        check_eq("dmem_addr", dmem_addr_o, addr - lo);
        check_eq("dmem_we", dmem_we_o, mw);
        if (mw) begin
          check_eq("dmem_be", dmem_be_o, exp_be);
          check_eq("dmem_wdata", dmem_wdata_o, exp_wdata);
        end
        if (busy_seen == lat) begin
          dmem_ack_i   = 1'b1;
          dmem_rdata_i = dmem[addr[5:2]];
          if (dmem_we_o)
            for (int unsigned j = 0; j < 4; j++)
              if (dmem_be_o[j]) dmem[addr[5:2]][8*j +: 8] = dmem_wdata_o[8*j +: 8];
        end
      end
      done = !stall_o;
      @(posedge clk_i); #1;
      dmem_ack_i = 1'b0;
      k++;
      if (!done && k > 30) begin
        check_eq("retire_bound", stall_o, 0);
        done = 1'b1;
      end
    end

    exp_rw = v && rw && !mis && !tmo;
    check_eq("busy_cycles", busy_seen, busy_exp);
    check_eq("regwrite", RegWrite_o, exp_rw);
    check_eq("fault", fault_o, mis);
    if (exp_rw) begin
      check_eq("rd", rd_o, rd);
      check_eq("wsrc", WriteSrc_o, ws);
      check_eq("aluout", ALUout_o, addr);
      check_eq("pcplus4", pcPlus4_o, pc4);
      check_eq("immop", ImmOp_o, imm);
    end
    if (acc && !mis && !tmo && !mw) check_eq("readdata", ReadData_o, exp_load);
    if (acc && !mis && !tmo && mw)
      for (int unsigned i = 0; i < sz; i++) mbyte[bi + i] = data[8*i +: 8];
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  f3;
    logic [1:0]  ws;
    logic        mw, v;
    int unsigned kind, sz, lo;
    logic [31:0] addr;

    for (int unsigned i = 0; i < 16; i++) set_word(i, $urandom);
    rst_i = 1'b1; valid_i = 1'b0; EQ_i = 1'b0; RegWrite_i = 1'b0; Branch_i = 1'b0;
    Jump_i = 1'b0; Ret_i = 1'b0; MemWrite_i = 1'b0; WriteSrc_i = '0; funct3_i = '0;
    ALUout_i = '0; ImmOp_i = '0; pcPlus4_i = '0; pcPlusImm_i = '0; regOp2_i = '0; rd_i = '0;
    dmem_ack_i = 1'b0; dmem_rdata_i = '0;
    repeat (2) @(posedge clk_i);
    #1;
    check_eq("rst_req", dmem_req_o, 0);
    check_eq("rst_regwrite", RegWrite_o, 0);
    check_eq("rst_fault", fault_o, 0);
    check_eq("rst_stall", stall_o, 0);
    check_eq("rst_readdata", ReadData_o, 0);
    check_eq("rst_be", dmem_be_o, 0);
    rst_i = 1'b0;

    // Reset while an access is outstanding; a late ack must not write back.
    valid_i = 1'b1; WriteSrc_i = 2'b01; RegWrite_i = 1'b1; funct3_i = 3'b010;
    ALUout_i = 32'h100; rd_i = 5'd7;
    @(posedge clk_i); #1;
    check_eq("rstbusy_req_up", dmem_req_o, 1);
    rst_i = 1'b1; valid_i = 1'b0;
    @(posedge clk_i); #1;
    check_eq("rstbusy_req_drop", dmem_req_o, 0);
    check_eq("rstbusy_regwrite", RegWrite_o, 0);
    @(posedge clk_i); #1;
    rst_i = 1'b0; dmem_ack_i = 1'b1; dmem_rdata_i = 32'h1234_5678;
    @(posedge clk_i); #1;
    dmem_ack_i = 1'b0;
    check_eq("late_ack_regwrite", RegWrite_o, 0);
    check_eq("late_ack_req", dmem_req_o, 0);
    @(posedge clk_i); #1;
    check_eq("late_ack_regwrite2", RegWrite_o, 0);
    check_eq("late_ack_fault", fault_o, 0);

    // Directed cases.
    set_word(0, 32'hDEAD_BEEF);
    run_instr(1, 0, 2'b01, 1, 3'b010, 32'h100, 32'h0, 0, 0, 0, 0, 32'h0, 5'd5, 3);   // LW, ack after 3
    set_word(0, 32'h8011_2233);
    run_instr(1, 0, 2'b01, 1, 3'b000, 32'h103, 32'h0, 0, 0, 0, 0, 32'h0, 5'd6, 1);   // LB
    run_instr(1, 0, 2'b01, 1, 3'b100, 32'h103, 32'h0, 0, 0, 0, 0, 32'h0, 5'd6, 2);   // LBU
    run_instr(1, 1, 2'b00, 0, 3'b001, 32'h102, 32'h0000_ABCD, 0, 0, 0, 0, 32'h0, 5'd0, 1); // SH
    run_instr(1, 0, 2'b01, 1, 3'b000, 32'h102, 32'h0, 0, 0, 0, 0, 32'h0, 5'd8, 1);   // LB reads SH lane
    run_instr(1, 0, 2'b01, 1, 3'b010, 32'h101, 32'h0, 0, 0, 0, 0, 32'h0, 5'd9, 1);   // misaligned LW
    run_instr(1, 0, 2'b01, 1, 3'b010, 32'h104, 32'h0, 0, 0, 0, 0, 32'h0, 5'd10, 100); // timeout
    run_instr(1, 0, 2'b01, 1, 3'b010, 32'h108, 32'h0, 0, 0, 0, 0, 32'h0, 5'd11, TO);  // ack on last cycle
    run_instr(1, 0, 2'b00, 0, 3'b000, 32'h0, 32'h0, 1, 0, 0, 1, 32'h40, 5'd0, 1);   // BEQ taken
    run_instr(1, 0, 2'b00, 0, 3'b000, 32'h0, 32'h0, 1, 0, 0, 0, 32'h40, 5'd0, 1);   // BEQ not taken
    run_instr(1, 0, 2'b10, 1, 3'b000, 32'h80, 32'h0, 0, 1, 1, 0, 32'h44, 5'd1, 1);  // JALR
    run_instr(0, 0, 2'b00, 1, 3'b000, 32'h80, 32'h0, 0, 1, 0, 0, 32'h44, 5'd1, 1);  // bubble

    // Randomized instruction stream.
    for (int unsigned n = 0; n < 300; n++) begin
      kind = $urandom_range(0, 2);
      v    = ($urandom_range(0, 7) != 0);
      mw   = (kind == 2);
      if (kind == 1) ws = 2'b01;
      else begin
        case ($urandom_range(0, 2))
          0:       ws = 2'b00;
          1:       ws = 2'b10;
          default: ws = 2'b11;
        endcase
      end
      f3 = 3'($urandom);
      if (kind == 0) addr = $urandom;
      else begin
        sz = acc_bytes(mw, f3);
        lo = $urandom_range(0, 3);
        if ($urandom_range(0, 3) != 0) lo = lo - (lo % sz);
        addr = 32'h100 + 32'($urandom_range(0, 15) * 4 + lo);
      end
      run_instr(v, mw, ws, 1'($urandom), f3, addr, $urandom,
                ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0), 1'($urandom),
                1'($urandom), $urandom, 5'($urandom), $urandom_range(1, TO + 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
Memory stage of the 5-stage RV32I pipeline. It consumes the EX/MEM register outputs and resolves branch, jump and return redirects. It runs loads and stores against a data-memory port with a req/ack handshake, stalling the front of the pipeline while an access is outstanding. It drives the MEM/WB register and the ALUResultM forwarding path back into EX.

Parameters:
TIMEOUT_CYCLES, 255, max cycles in BUSY without ack before the access is aborted (≥1)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
valid_i  in  1  EX/MEM holds a live instruction (0 = bubble)
EQ_i  in  1  ALU equality flag
ALUout_i  in  32  ALU result / memory address
RegWrite_i  in  1  writeback enable
WriteSrc_i  in  2  00 ALU, 01 memory, 10 pcPlus4, 11 ImmOp
Branch_i, Jump_i, Ret_i  in  1 each  control-flow type
MemWrite_i  in  1  store
funct3_i  in  3  access size/sign
ImmOp_i, pcPlus4_i, pcPlusImm_i, regOp2_i  in  32 each  EX/MEM data
rd_i  in  5  destination register
ALUResultM_o  out  32  = ALUout_i, combinational forward to EX
stall_o  out  1  freeze PC, IF/ID, ID/EX, EX/MEM
PCsrc_o  out  1  redirect taken (also flush IF/ID, ID/EX)
PCtarget_o  out  32  redirect target
dmem_req_o, dmem_we_o  out  1 each  request, write
dmem_addr_o  out  32  word-aligned address
dmem_wdata_o  out  32  lane-replicated store data
dmem_be_o  out  4  byte enables
dmem_ack_i  in  1  access complete; rdata valid same cycle
dmem_rdata_i  in  32  read word
RegWrite_o, WriteSrc_o(2), ALUout_o(32), ReadData_o(32), pcPlus4_o(32), ImmOp_o(32), rd_o(5)  out  MEM/WB register
fault_o  out  1  one-cycle pulse: misaligned or timed-out access

Behaviour:
- Reset: FSM=IDLE; all registered outputs 0, including dmem_req_o, the MEM/WB fields and fault_o. Reset in BUSY aborts with no writeback. An ack arriving after reset is ignored.
- acc = valid_i & (MemWrite_i | WriteSrc_i==01).
- mis = halfword & addr[0], or word & addr[1:0]!=0.
- FSM IDLE: acc & !mis → stall_o=1, latch addr/wdata/be/we, dmem_req_o=1 next cycle, go BUSY. acc & mis → no request, fault_o pulse, MEM/WB loads bubble (RegWrite_o=0).
- FSM BUSY: dmem_req_o and its fields held stable; stall_o=1; counter increments.
  - ack → capture extended rdata, drop req next cycle, go DONE.
  - counter == TIMEOUT_CYCLES-1 without ack → drop req, fault_o pulse, go DONE with RegWrite suppressed.
- FSM DONE: stall_o=0. MEM/WB loads the instruction (ReadData_o = captured data). Go IDLE. The next EX/MEM instruction is seen in the following cycle, so no re-issue.
- Minimum memory-instruction occupancy: 3 cycles (stall 2).
- Non-memory instructions: MEM/WB loads inputs 1 cycle later, no stall.
- While stall_o=1: MEM/WB loads a bubble each cycle.
- Loads (funct3): 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Lane selected by addr[1:0]; sign- or zero-extend to 32.
- Stores: SB be=0001<<addr[1:0], wdata={4{b}}. SH be=0011<<addr[1:0], wdata={2{h}}. SW be=1111.
- Unlisted funct3 values are treated as word.
- Control flow is combinational and gated by valid_i & !stall_o:
  - PCsrc_o = (Branch_i & EQ_i) | Jump_i.
  - PCtarget_o = Ret_i ? ALUout_i : pcPlusImm_i.
- ALUResultM_o is ungated.

Decomposition:
- Shared package riscv_pkg holds: WriteSrc encodings, funct3 load/store constants, mem FSM state enum.
- One sub-module, load_store_align: combinational address/funct3 → be, wdata lanes, mis flag, load extension. Unit-tested alone.

Test Plan:
- Reset: rst_i=1 for 2 cycles while in BUSY → next cycle dmem_req_o=0, RegWrite_o=0; an ack 1 cycle later causes no writeback.
- LW, addr 0x100, ack after 3 BUSY cycles, rdata 0xDEADBEEF:
  - stall_o high 4 cycles, then RegWrite_o=1, ReadData_o=0xDEADBEEF, rd_o propagated.
- LB, addr 0x103, rdata 0x80112233 → ReadData_o=0xFFFFFF80. Same with LBU → 0x00000080.
- SH, addr 0x102, regOp2 0x0000ABCD → dmem_be_o=1100, dmem_wdata_o=0xABCDABCD, dmem_we_o=1, RegWrite_o=0.
- LW, addr 0x101 → no dmem_req_o, fault_o one-cycle pulse, no stall, RegWrite_o=0.
- Timeout and control flow, with TIMEOUT_CYCLES=4:
  - Never ack → req dropped after 4 BUSY cycles, fault_o pulse.
  - BEQ with EQ_i=1 and pcPlusImm 0x40 → PCsrc_o=1, PCtarget_o=0x40.
  - JALR with Ret_i, ALUout 0x80 → PCtarget_o=0x80.
